// File: rtl/fir_stream_checker_if.sv
// Stream bundle between the golden-model source, the filter output and the checker.
// The checker consumes it through the slave modport.
interface fir_stream_checker_if #(
    parameter int unsigned NB = 8
);
    logic          exp_v;
    logic [NB-1:0] exp_d;
    logic          exp_rdy;
    logic          vin;
    logic [NB-1:0] din;

    modport master (
        output exp_v,
        output exp_d,
        output vin,
        output din,
        input  exp_rdy
    );

    modport slave (
        input  exp_v,
        input  exp_d,
        input  vin,
        input  din,
        output exp_rdy
    );
endinterface

// File: rtl/fir_stream_checker.sv
// Self-checking sink for the FIR output stream: buffers expected samples in a FIFO,
// compares every valid filter output in order, counts samples/errors and flags end of run.
module fir_stream_checker #(
    parameter int unsigned NB        = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned N_SAMPLES = 256,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    fir_stream_checker_if.slave  stream_io,
    output logic                 mismatch_o,
    output logic [15:0]          smp_cnt_o,
    output logic [15:0]          err_cnt_o,
    output logic                 underrun_o,
    output logic                 timeout_err_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 end_sim_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [NB-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [15:0]   smp_q, smp_d;
    logic [15:0]   err_q, err_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          mis_q, mis_d;
    logic          und_q, und_d;
    logic          tmo_q, tmo_d;

    logic full, empty, push, pop, vin_run, cmp_fail;

    assign full     = (occ_q == (AW + 1)'(DEPTH));
    assign empty    = (occ_q == '0);
    assign push     = stream_io.exp_v & ~full;
    assign vin_run  = (state_q == StRun) & stream_io.vin;
    // No bypass: a pop needs an entry that was already stored before this cycle.
    assign pop      = vin_run & ~empty;
    assign cmp_fail = empty | (mem_q[rd_ptr_q] != stream_io.din);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) occ_d = occ_q + 1'b1;
        if (pop && !push) occ_d = occ_q - 1'b1;
    end

    // Run control, comparison and counters next-state
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        err_d   = err_q;
        idle_d  = idle_q;
        und_d   = und_q;
        tmo_d   = tmo_q;
        mis_d   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRun;
                    smp_d   = '0;
                    err_d   = '0;
                    idle_d  = '0;
                    und_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            StRun: begin
                if (stream_io.vin) begin
                    idle_d = '0;
                    smp_d  = smp_q + 16'd1;
                    if (cmp_fail) begin
                        mis_d = 1'b1;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end
                    if (empty) und_d = 1'b1;
                    // Sample completion takes priority over any timeout.
                    if (smp_d == 16'(N_SAMPLES)) state_d = StDone;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Expected-sample storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= stream_io.exp_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            smp_q    <= '0;
            err_q    <= '0;
            idle_q   <= '0;
            mis_q    <= 1'b0;
            und_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            smp_q    <= smp_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
            mis_q    <= mis_d;
            und_q    <= und_d;
            tmo_q    <= tmo_d;
        end
    end

    assign stream_io.exp_rdy = ~full;
    assign mismatch_o        = mis_q;
    assign smp_cnt_o         = smp_q;
    assign err_cnt_o         = err_q;
    assign underrun_o        = und_q;
    assign timeout_err_o     = tmo_q;
    assign busy_o            = (state_q == StRun);
    assign done_o            = (state_q == StDone);
    assign end_sim_o         = (state_q == StDone);
endmodule
